// File: rtl/signal_meas.sv
// Windowed ADC measurement stage: max/min/p2p/mean, Schmitt rising-crossing count and period.
// Results are registered at window completion and held until the next window finishes.
module signal_meas #(
    parameter int unsigned WINDOW_LOG2 = 8,
    parameter int unsigned HYST        = 16,
    parameter int unsigned PER_W       = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_valid,
    input  logic [11:0]            sample,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [11:0]            max_out,
    output logic [11:0]            min_out,
    output logic [11:0]            p2p_out,
    output logic [11:0]            mean_out,
    output logic [WINDOW_LOG2:0]   cross_count,
    output logic [PER_W-1:0]       period_clks,
    output logic                   period_valid
);

    localparam int unsigned SW    = 12;
    localparam int unsigned SUM_W = SW + WINDOW_LOG2;
    localparam int unsigned CW    = WINDOW_LOG2 + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACQ  = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WINDOW_LOG2-1:0] CNT_LAST  = '1;
    localparam logic [CW-1:0]          CROSS_MAX = CW'(1) << WINDOW_LOG2;
    localparam logic [SW-1:0]          THR_INIT  = SW'(2048);

    logic [1:0]             state, next_state;
    logic [WINDOW_LOG2-1:0] cnt;
    logic [SW-1:0]          max_r, min_r, thr;
    logic [SUM_W-1:0]       sum_r;
    logic                   schm_high;
    logic [CW-1:0]          cross_r;
    logic [PER_W-1:0]       per_cnt, per_cand, per_inc;

    logic [SW:0]            hi_sum, mid_sum;
    logic [SW-1:0]          thr_hi, thr_lo;
    logic                   first_smp;

    // Saturating Schmitt thresholds around the adaptive mid-level
    assign hi_sum    = {1'b0, thr} + (SW+1)'(HYST);
    assign thr_hi    = hi_sum[SW] ? '1 : hi_sum[SW-1:0];
    assign thr_lo    = (thr >= SW'(HYST)) ? (thr - SW'(HYST)) : '0;
    assign mid_sum   = {1'b0, max_r} + {1'b0, min_r};
    assign per_inc   = (per_cnt == '1) ? per_cnt : (per_cnt + PER_W'(1));
    assign first_smp = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_ACQ;
            S_ACQ:   if (sample_valid && (cnt == CNT_LAST)) next_state = S_CALC;
            S_CALC:  next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            max_out      <= '0;
            min_out      <= '0;
            p2p_out      <= '0;
            mean_out     <= '0;
            cross_count  <= '0;
            period_clks  <= '0;
            period_valid <= 1'b0;
            cnt          <= '0;
            max_r        <= '0;
            min_r        <= '0;
            sum_r        <= '0;
            schm_high    <= 1'b0;
            cross_r      <= '0;
            per_cnt      <= '0;
            per_cand     <= '0;
            thr          <= THR_INIT;
        end else begin
            done <= 1'b0;
            busy <= (next_state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        cross_r  <= '0;
                        per_cnt  <= '0;
                        per_cand <= '0;
                    end
                end
                S_ACQ: begin
                    per_cnt <= per_inc;
                    if (sample_valid) begin
                        cnt <= cnt + WINDOW_LOG2'(1);
                        if (first_smp) begin
                            max_r     <= sample;
                            min_r     <= sample;
                            sum_r     <= SUM_W'(sample);
                            schm_high <= (sample >= thr);
                        end else begin
                            if (sample > max_r) max_r <= sample;
                            if (sample < min_r) min_r <= sample;
                            sum_r <= sum_r + SUM_W'(sample);
                            // Rising crossing restarts the period counter; 2nd+ crossings latch a period
                            if (!schm_high && (sample >= thr_hi)) begin
                                schm_high <= 1'b1;
                                per_cnt   <= '0;
                                if (cross_r != CROSS_MAX) cross_r <= cross_r + CW'(1);
                                if (cross_r != '0) per_cand <= per_inc;
                            end else if (schm_high && (sample <= thr_lo)) begin
                                schm_high <= 1'b0;
                            end
                        end
                    end
                end
                S_CALC: begin
                    done         <= 1'b1;
                    max_out      <= max_r;
                    min_out      <= min_r;
                    p2p_out      <= max_r - min_r;
                    mean_out     <= sum_r[SUM_W-1 -: SW];
                    cross_count  <= cross_r;
                    period_valid <= (cross_r >= CW'(2));
                    period_clks  <= (cross_r >= CW'(2)) ? per_cand : '0;
                end
                S_DONE: begin
                    thr <= mid_sum[SW:1];
                end
                default: ;
            endcase
        end
    end

endmodule
